// File: rtl/axi_stream_remove_header.sv
// Strips a 0..DATA_BYTE_WD byte header from the front of each AXI-Stream
// packet. The payload is realigned to beat boundaries and the removed bytes
// are reported on a side port. A residue register holds the low bytes of the
// previous beat. Those bytes are merged with the top bytes of the next beat.
module axi_stream_remove_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD:0]    byte_remove_cnt,
  output logic                    ready_remove,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      data_header,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  output logic                    err_short
);

  localparam int CW = BYTE_CNT_WD + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_STREAM, S_FLUSH} state_t;

  // Number of valid bytes in a keep vector
  function automatic int count_keep(input logic [DATA_BYTE_WD-1:0] k);
    int n;
    n = 0;
    for (int i = 0; i < DATA_BYTE_WD; i++) n = n + (k[i] ? 1 : 0);
    return n;
  endfunction

  // The first n bytes of a beat are valid, so the keep bits are set from the MSB down
  function automatic logic [DATA_BYTE_WD-1:0] msb_keep(input int n);
    logic [DATA_BYTE_WD-1:0] k;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (i < n);
    return k;
  endfunction

  // Header keep is right-aligned: (1<<n)-1
  function automatic logic [DATA_BYTE_WD-1:0] lsb_keep(input int n);
    logic [DATA_BYTE_WD-1:0] k;
    for (int i = 0; i < DATA_BYTE_WD; i++) k[i] = (i < n);
    return k;
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int j = 0; j < DATA_BYTE_WD; j++) m[8*j +: 8] = {8{k[j]}};
    return m;
  endfunction

  state_t                  state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  cnt_t                    flush_q, flush_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic                    valid_out_q, valid_out_d;
  logic [DATA_WD-1:0]      data_out_q, data_out_d;
  logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
  logic                    last_out_q, last_out_d;
  logic                    valid_header_q, valid_header_d;
  logic [DATA_WD-1:0]      data_header_q, data_header_d;
  logic [DATA_BYTE_WD-1:0] keep_header_q, keep_header_d;
  logic                    err_short_q, err_short_d;

  logic                    out_free, accept, load, nl;
  logic [DATA_WD-1:0]      nd;
  logic [DATA_BYTE_WD-1:0] nk;
  int                      l_c, c_c, r_c;

  // Output register can take a new beat when it is empty or being drained
  assign out_free     = !valid_out_q || ready_out;
  assign ready_remove = !rst && (state_q == S_IDLE);
  assign ready_in     = !rst && ((state_q == S_FIRST) || (state_q == S_STREAM)) && out_free;
  assign accept       = valid_in && ready_in;

  // Next-state, residue and output-register load logic
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush_d        = flush_q;
    res_d          = res_q;
    valid_out_d    = valid_out_q && !ready_out;
    data_out_d     = data_out_q;
    keep_out_d     = keep_out_q;
    last_out_d     = last_out_q;
    valid_header_d = 1'b0;
    data_header_d  = data_header_q;
    keep_header_d  = keep_header_q;
    err_short_d    = 1'b0;
    load           = 1'b0;
    nd             = '0;
    nk             = '0;
    nl             = 1'b0;
    l_c            = count_keep(keep_in);
    c_c            = int'(cnt_q);
    r_c            = DATA_BYTE_WD - c_c;

    case (state_q)
      S_IDLE: begin
        if (valid_remove && ready_remove) begin
          cnt_d   = (byte_remove_cnt > cnt_t'(DATA_BYTE_WD)) ? cnt_t'(DATA_BYTE_WD)
                                                            : byte_remove_cnt;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (accept) begin
          res_d = data_in << (8 * c_c);
          if (last_in && (l_c <= c_c)) begin
            // Packet has no payload byte left once the header is removed, so it is dropped
            err_short_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            if (c_c > 0) begin
              valid_header_d = 1'b1;
              data_header_d  = data_in >> (8 * r_c);
              keep_header_d  = lsb_keep(c_c);
            end
            if (last_in) begin
              flush_d = cnt_t'(l_c - c_c);
              state_d = S_FLUSH;
            end else begin
              state_d = S_STREAM;
            end
          end
        end
      end
      S_STREAM: begin
        if (accept) begin
          res_d = data_in << (8 * c_c);
          load  = 1'b1;
          nd    = res_q | (data_in >> (8 * r_c));
          nk    = '1;
          if (last_in) begin
            if (l_c <= c_c) begin
              nk      = msb_keep(r_c + l_c);
              nl      = 1'b1;
              state_d = S_IDLE;
            end else begin
              flush_d = cnt_t'(l_c - c_c);
              state_d = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (out_free) begin
          load    = 1'b1;
          nd      = res_q;
          nk      = msb_keep(int'(flush_q));
          nl      = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      valid_out_d = 1'b1;
      data_out_d  = nd & byte_mask(nk);
      keep_out_d  = nk;
      last_out_d  = nl;
    end
  end

  // State, residue and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      flush_q        <= '0;
      res_q          <= '0;
      valid_out_q    <= 1'b0;
      data_out_q     <= '0;
      keep_out_q     <= '0;
      last_out_q     <= 1'b0;
      valid_header_q <= 1'b0;
      data_header_q  <= '0;
      keep_header_q  <= '0;
      err_short_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      flush_q        <= flush_d;
      res_q          <= res_d;
      valid_out_q    <= valid_out_d;
      data_out_q     <= data_out_d;
      keep_out_q     <= keep_out_d;
      last_out_q     <= last_out_d;
      valid_header_q <= valid_header_d;
      data_header_q  <= data_header_d;
      keep_header_q  <= keep_header_d;
      err_short_q    <= err_short_d;
    end
  end

  assign valid_out    = valid_out_q;
  assign data_out     = data_out_q;
  assign keep_out     = keep_out_q;
  assign last_out     = last_out_q;
  assign valid_header = valid_header_q;
  assign data_header  = data_header_q;
  assign keep_header  = keep_header_q;
  assign err_short    = err_short_q;

endmodule
